// File: rtl/fir_uart_pkg.sv
// Shared types and helpers for the FIR sample UART transmitter.
package fir_uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } tx_state_t;

   localparam int DATA_BITS = 8;

   // Bytes needed to carry one WIDTH+3 bit filter result.
   function automatic int nbytes(input int width);
      return (width + 3 + DATA_BITS - 1) / DATA_BITS;
   endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// One UART byte frame: start, 8 data bits LSB first, optional even parity, stop.
// Parity stage present only when FIR_UART_TX_PARITY_EN is defined.
module uart_byte_tx
   import fir_uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic                 CLK,
   input  logic                 rst,
   input  logic                 start_i,
   input  logic [DATA_BITS-1:0] data_i,
   output logic                 tx_o,
   output logic                 done_o
);

   localparam int CW = $clog2(CLKS_PER_BIT);

   tx_state_t            state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [2:0]           bit_q, bit_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 tx_q, tx_d;
   logic                 tc;
   logic                 load;
`ifdef FIR_UART_TX_PARITY_EN
   logic                 par_q, par_d;
`endif

   assign tc     = (cnt_q == CW'(CLKS_PER_BIT - 1));
   assign done_o = (state_q == STOP) && tc;
   // A new byte may start from IDLE or directly out of the last stop cycle.
   assign load   = start_i && ((state_q == IDLE) || done_o);
   assign tx_o   = tx_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = tc ? '0 : cnt_q + 1'b1;
      bit_d   = bit_q;
      shift_d = shift_q;
      tx_d    = tx_q;
`ifdef FIR_UART_TX_PARITY_EN
      par_d   = par_q;
`endif
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            tx_d  = 1'b1;
         end
         START: begin
            if (tc) begin
               state_d = DATA;
               bit_d   = 3'd0;
               tx_d    = shift_q[0];
            end
         end
         DATA: begin
            if (tc) begin
               if (bit_q == 3'd7) begin
`ifdef FIR_UART_TX_PARITY_EN
                  state_d = PARITY;
                  tx_d    = par_q;
`else
                  state_d = STOP;
                  tx_d    = 1'b1;
`endif
               end else begin
                  bit_d   = bit_q + 3'd1;
                  shift_d = shift_q >> 1;
                  tx_d    = shift_q[1];
               end
            end
         end
`ifdef FIR_UART_TX_PARITY_EN
         PARITY: begin
            if (tc) begin
               state_d = STOP;
               tx_d    = 1'b1;
            end
         end
`endif
         STOP: begin
            if (tc) begin
               state_d = IDLE;
               tx_d    = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            tx_d    = 1'b1;
         end
      endcase
      if (load) begin
         state_d = START;
         cnt_d   = '0;
         shift_d = data_i;
         tx_d    = 1'b0;
`ifdef FIR_UART_TX_PARITY_EN
         par_d   = ^data_i;
`endif
      end
   end

   always_ff @(posedge CLK) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         bit_q   <= 3'd0;
         shift_q <= '0;
         tx_q    <= 1'b1;
`ifdef FIR_UART_TX_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
`ifdef FIR_UART_TX_PARITY_EN
         par_q   <= par_d;
`endif
      end
   end

endmodule

// File: rtl/fir_uart_tx.sv
// Word-level UART transmitter: latches a WIDTH+3 bit sample and sends it LSB byte first.
// Optional even parity per byte via FIR_UART_TX_PARITY_EN.
module fir_uart_tx
   import fir_uart_pkg::*;
#(
   parameter int WIDTH        = 16,
   parameter int CLKS_PER_BIT = 868
) (
   input  logic             CLK,
   input  logic             rst,
   input  logic [WIDTH+2:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             tx,
   output logic             busy,
   output logic [15:0]      drop_cnt
);

   localparam int NB = nbytes(WIDTH);
   localparam int WW = DATA_BITS * NB;
   localparam int IW = (NB > 1) ? $clog2(NB) : 1;

   logic [WW-1:0]        word_ext;
   logic [WW-1:0]        word_q, word_d;
   logic [IW-1:0]        idx_q, idx_d;
   logic                 busy_q, busy_d;
   logic                 ready_q, ready_d;
   logic [15:0]          drop_q, drop_d;
   logic                 accept;
   logic                 last_byte;
   logic                 byte_done;
   logic                 byte_start;
   logic [DATA_BITS-1:0] byte_data;

   assign word_ext   = WW'(in_data);
   assign accept     = in_valid && ready_q;
   assign last_byte  = (idx_q == IW'(NB - 1));
   assign byte_start = accept || (byte_done && !last_byte);
   // Byte 0 goes straight from the input; word_q holds only the bytes still to send.
   assign byte_data  = accept ? word_ext[DATA_BITS-1:0] : word_q[DATA_BITS-1:0];

   always_comb begin
      word_d  = word_q;
      idx_d   = idx_q;
      busy_d  = busy_q;
      ready_d = ready_q;
      drop_d  = drop_q;
      if (accept) begin
         word_d  = word_ext >> DATA_BITS;
         idx_d   = '0;
         busy_d  = 1'b1;
         ready_d = 1'b0;
      end else if (byte_done) begin
         if (last_byte) begin
            busy_d  = 1'b0;
            ready_d = 1'b1;
         end else begin
            idx_d  = idx_q + 1'b1;
            word_d = word_q >> DATA_BITS;
         end
      end else if (!busy_q) begin
         ready_d = 1'b1;
      end
      if (in_valid && !ready_q && (drop_q != 16'hFFFF)) begin
         drop_d = drop_q + 16'd1;
      end
   end

   always_ff @(posedge CLK) begin
      if (!rst) begin
         word_q  <= '0;
         idx_q   <= '0;
         busy_q  <= 1'b0;
         ready_q <= 1'b0;
         drop_q  <= 16'd0;
      end else begin
         word_q  <= word_d;
         idx_q   <= idx_d;
         busy_q  <= busy_d;
         ready_q <= ready_d;
         drop_q  <= drop_d;
      end
   end

   uart_byte_tx #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_byte (
      .CLK    (CLK),
      .rst    (rst),
      .start_i(byte_start),
      .data_i (byte_data),
      .tx_o   (tx),
      .done_o (byte_done)
   );

   assign in_ready = ready_q;
   assign busy     = busy_q;
   assign drop_cnt = drop_q;

endmodule

// File: tb/tb_fir_uart_tx.sv
// Directed bench for fir_uart_tx with WIDTH=16, CLKS_PER_BIT=4 (three bytes per word).
module tb_fir_uart_tx;

   localparam int W   = 16;
   localparam int CPB = 4;
   localparam int NB  = 3;
`ifdef FIR_UART_TX_PARITY_EN
   localparam int FB  = 11;
`else
   localparam int FB  = 10;
`endif
   localparam int T   = NB * FB * CPB;

   logic          CLK = 1'b0;
   logic          rst;
   logic [W+2:0]  in_data;
   logic          in_valid;
   logic          in_ready;
   logic          tx;
   logic          busy;
   logic [15:0]   drop_cnt;

   int n_vec = 0;
   int n_bad = 0;
   int exp_drop = 0;

   fir_uart_tx #(
      .WIDTH       (W),
      .CLKS_PER_BIT(CPB)
   ) dut (
      .CLK     (CLK),
      .rst     (rst),
      .in_data (in_data),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .tx      (tx),
      .busy    (busy),
      .drop_cnt(drop_cnt)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Expected line level j cycles after the accept edge.
   function automatic logic exp_bit(input logic [23:0] w, input int j);
      int p, b, k;
      logic [23:0] sh;
      logic [7:0]  byt;
      p   = j / CPB;
      b   = p / FB;
      k   = p % FB;
      sh  = w >> (8 * b);
      byt = sh[7:0];
      if (k == 0) return 1'b0;
      if (k <= 8) return byt[k-1];
      if (FB == 11 && k == 9) return ^byt;
      return 1'b1;
   endfunction

   // Offer w; returns at the first negedge after the accept edge.
   task automatic start_word(input logic [18:0] w, input bit hold, input logic [18:0] nxt);
      int g;
      in_data  = w;
      in_valid = 1'b1;
      g = 0;
      while (!in_ready && g < 1000) begin
         @(negedge CLK);
         g++;
      end
      chk("accept_ready", in_ready, 1'b1);
      @(negedge CLK);
      if (hold) begin
         in_data = nxt;
      end else begin
         in_valid = 1'b0;
         in_data  = ~w;
      end
      chk("ready_low_after_accept", in_ready, 1'b0);
   endtask

   task automatic check_frame(input logic [18:0] w, input int n);
      for (int j = 0; j < n; j++) begin
         chk($sformatf("tx w=%05h j=%0d", w, j), tx, exp_bit({5'b0, w}, j));
         chk($sformatf("busy w=%05h j=%0d", w, j), busy, 1'b1);
         @(negedge CLK);
      end
   endtask

   task automatic send_word(input logic [18:0] w, input bit hold, input logic [18:0] nxt);
      start_word(w, hold, nxt);
      check_frame(w, T);
      if (hold) exp_drop += T;
      chk("busy_end", busy, 1'b0);
      chk("ready_end", in_ready, 1'b1);
      chk("tx_idle_end", tx, 1'b1);
      chk("drop_end", drop_cnt, exp_drop[15:0]);
      $display("word %05h sent: %0d cycles busy, drop_cnt=%0d", w, T, drop_cnt);
   endtask

   initial begin
      int g;
      rst      = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;
      repeat (3) @(negedge CLK);
      chk("rst_tx", tx, 1'b1);
      chk("rst_busy", busy, 1'b0);
      chk("rst_ready", in_ready, 1'b0);
      chk("rst_drop", drop_cnt, 16'd0);
      rst = 1'b1;
      chk("ready_before_first_edge", in_ready, 1'b0);
      @(negedge CLK);
      chk("ready_after_release", in_ready, 1'b1);
      chk("tx_after_release", tx, 1'b1);
      $display("reset released");

      // Single word: bytes C1, A3, 05.
      send_word(19'h5A3C1, 1'b0, '0);

      // Back-to-back with in_valid held; refusals during the first word are counted.
      send_word(19'h00001, 1'b1, 19'h7FFFF);
      send_word(19'h7FFFF, 1'b0, '0);

      // Parity-sensitive bytes A3 and 07.
      send_word(19'h007A3, 1'b0, '0);

      // Reset during a data-zero bit of the second byte.
      start_word(19'h10045, 1'b0, '0);
      check_frame(19'h10045, 50);
      chk("pre_reset_tx_low", tx, 1'b0);
      rst = 1'b0;
      @(negedge CLK);
      chk("midrst_tx", tx, 1'b1);
      chk("midrst_busy", busy, 1'b0);
      chk("midrst_ready", in_ready, 1'b0);
      chk("midrst_drop", drop_cnt, 16'd0);
      exp_drop = 0;
      $display("reset asserted mid-frame");
      rst = 1'b1;
      @(negedge CLK);
      chk("ready_after_midrst", in_ready, 1'b1);
      send_word(19'h0ABCD, 1'b0, '0);

      // Saturation of the refusal counter with in_valid held for many words.
      in_data  = '0;
      in_valid = 1'b1;
      repeat (66500) @(negedge CLK);
      chk("drop_saturated", drop_cnt, 16'hFFFF);
      repeat (300) @(negedge CLK);
      chk("drop_held", drop_cnt, 16'hFFFF);
      in_valid = 1'b0;
      g = 0;
      while (busy && g < 1000) begin
         @(negedge CLK);
         g++;
      end
      chk("idle_after_saturation", busy, 1'b0);
      $display("saturation run done, drop_cnt=%0h", drop_cnt);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/fir_uart_tx.md
# fir_uart_tx

Serial transmitter for filtered FIR output samples. It accepts one `WIDTH+3`-bit filter result through a valid/ready handshake and splits it into `NBYTES` bytes, least significant byte first. Each byte is sent as an 8N1 UART frame on `tx`. It sits after the moving-average filter (plus any upstream decimation strobe) and is the board's off-chip data path.

## Interface
- `WIDTH`, 16: filter input sample width. The data word is `WIDTH+3` bits; `WIDTH` ranges 5..29.
- `CLKS_PER_BIT`, 868: `CLK` cycles per UART bit (100 MHz / 115200). Minimum 2.
- `CLK` input, 1: system clock; all logic on the rising edge.
- `rst` input, 1: reset, synchronous and active-low.
- `in_data` input, `WIDTH+3`: filtered sample.
- `in_valid` input, 1: sample strobe.
- `in_ready` output, 1: transmitter can accept a word.
- `tx` output, 1: UART line, idle high.
- `busy` output, 1: a word is being transmitted.
- `drop_cnt` output, 16: count of offered-but-refused words; saturates at 16'hFFFF.

## Operation
- Derived constant: `NBYTES = ceil((WIDTH+3)/8)`. The word is zero-extended to `8*NBYTES` bits and latched into a shift register.
- State machine `IDLE -> START -> DATA -> [PARITY] -> STOP`, then either `START` for the next byte or `IDLE` after the last byte.
- `IDLE`: `tx`=1, `in_ready`=1, `busy`=0. On `in_valid && in_ready`:
  - latch the word;
  - clear the byte index;
  - go to `START`.
- `START`: `tx`=0 for one bit period.
- `DATA`: 8 bits, LSB first. The bit counter runs 0..7.
- `STOP`: `tx`=1 for one bit period. Then:
  - if the byte index is `NBYTES-1`, go to `IDLE`;
  - otherwise increment the index, shift the word right 8 bits, and go to `START`. There is no inter-byte gap.
- Bit-period counter: counts 0..`CLKS_PER_BIT-1`. It advances state or bit on the terminal count and clears on every state change.
- `drop_cnt`: increments on every cycle where `in_valid=1` and `in_ready=0`, and saturates.
- Refused words are discarded. There is no buffering.
- `in_data` is sampled only on the accept cycle. Later changes do not affect the frame in flight.
- Reset mid-frame: the next rising edge with `rst=0` forces the reset state and truncates the frame. `tx` returns high immediately.

## Timing
- Reset values: `tx`=1, `in_ready`=0, `busy`=0, `drop_cnt`=0, state `IDLE`.
- `in_ready` is registered. It rises on the first edge after `rst` deasserts.
- Accept at edge N:
  - `tx` falls, `busy` rises and `in_ready` falls, all at edge N+1.
- The first start bit spans edges N+1..N+1+`CLKS_PER_BIT`.
- Each frame is 10 bit periods (11 with parity).
- `busy` falls and `in_ready` rises at edge N+1+`NBYTES`·10·`CLKS_PER_BIT`. A new word can be accepted at that edge.
- `in_valid` during the final stop bit counts as a drop.
- `drop_cnt` updates at the edge following the refused cycle.

## Configuration
- `FIR_UART_TX_PARITY_EN`:
  - Defined: a `PARITY` state is inserted between `DATA` and `STOP`. It transmits the even parity (XOR) of the 8 data bits. Frames are 11 bits, so word time is `NBYTES`·11·`CLKS_PER_BIT`.
  - Undefined: the `PARITY` state and its logic are absent, and frames are 8N1.

## Structure
- Package `fir_uart_pkg` holds:
  - `tx_state_t` enum: `IDLE`, `START`, `DATA`, `PARITY`, `STOP`;
  - the `DATA_BITS`=8 constant;
  - the `nbytes(width)` function.
- Sub-module `uart_byte_tx` handles one byte frame: start, data, optional parity and stop, with the bit-period counter. It has a `start`/`done` handshake.
- The top level holds word latching, byte sequencing, the handshake and `drop_cnt`.

## Test plan
All scenarios use `CLKS_PER_BIT`=4 and `WIDTH`=16 (`NBYTES`=3).
- Reset release, no input: `tx`=1, `busy`=0, `in_ready`=0 in the first cycle, then 1. `drop_cnt`=0.
- Word 19'h5A3C1 → bytes C1, A3, 05, each framed 0 + LSB-first bits + 1, 4 cycles per bit. `busy` is high for 120 cycles.
- Back-to-back: `in_valid` held high with 19'h00001 then 19'h7FFFF. The second word is accepted on the edge `busy` falls; `tx` stays high for no extra bit period between words.
- Overrun: `in_valid` pulsed every cycle during one 120-cycle word → `drop_cnt`=120 after the word. With `drop_cnt` preset near saturation, it holds at 16'hFFFF.
- Reset asserted at cycle 50 of a frame → `tx`=1, `busy`=0 at the next edge. The next word transmits cleanly from its start bit.
- With `FIR_UART_TX_PARITY_EN`, byte A3 → parity bit 0; byte 07 → parity bit 1. The word lasts 132 cycles.
